// File: rtl/tage_upd_seq.sv
// TAGE update sequencer: queues FTQ update bundles and
// serialises them into single-port TAGE table writes.
package tage_upd_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  num;
    logic [2:0]  ctr;
    logic [2:0]  u;
    logic        nw;
    logic [2:0]  nnum;
    logic [2:0]  nctr;
    logic [2:0]  nu;
    logic [5:0]  dec;
    logic [17:0] decu;
  } bndl_t;

  typedef enum logic [1:0] {
    IDLE,
    PRV,
    NEW,
    DEC
  } st_t;
endpackage

module tage_upd_seq
  import tage_upd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDXW  = 8,
  parameter int TAGW  = 8
) (
  input  logic            Clk,
  input  logic            Rest,
  input  logic            UpdAble,
  input  logic [31:0]     UpdPc,
  input  logic [2:0]      UpdNum,
  input  logic [2:0]      UpdCtr,
  input  logic [2:0]      UpdU,
  input  logic            NewAble,
  input  logic [2:0]      NewNum,
  input  logic [2:0]      NewCtr,
  input  logic [2:0]      NewU,
  input  logic [5:0]      DecAble,
  input  logic [17:0]     DecU,
  output logic            UpdFull,
  output logic            UpdBusy,
  output logic [7:0]      DropCnt,
  output logic            TblWe,
  input  logic            TblRdy,
  output logic [2:0]      TblSel,
  output logic [IDXW-1:0] TblIdx,
  output logic [TAGW-1:0] TblTag,
  output logic [2:0]      TblCtr,
  output logic [2:0]      TblU,
  output logic            TblWrCtr,
  output logic            TblWrTag,
  output logic            TblWrU
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULLC = (PW+1)'(DEPTH);

  bndl_t           mem [DEPTH];
  bndl_t           inb;
  bndl_t           hd;
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic [PW:0]     cnt;
  logic [PW:0]     cnt_nx;
  logic            full_q;
  logic [7:0]      drop;
  st_t             st;
  st_t             st_nx;
  logic [5:0]      clr;
  logic [5:0]      clr_nx;
  logic [5:0]      eff;
  logic [5:0]      rem;
  logic [5:0]      low;
  logic [2:0]      lt;
  logic [2:0]      lu;
  logic            enq;
  logic            pop;
  logic            acc;
  logic [IDXW-1:0] plo;
  logic [IDXW-1:0] phi;
  logic [TAGW-1:0] ptg;
  logic            unused_ok;

  function automatic logic [IDXW-1:0] hidx(
    input logic [IDXW-1:0] lo,
    input logic [IDXW-1:0] hi,
    input logic [2:0]      t
  );
    return lo ^ (hi >> t);
  endfunction

  function automatic logic [TAGW-1:0] htag(
    input logic [TAGW-1:0] tg,
    input logic [2:0]      t
  );
    return tg ^ TAGW'(t);
  endfunction

  assign inb = '{
    pc:   UpdPc,
    num:  UpdNum,
    ctr:  UpdCtr,
    u:    UpdU,
    nw:   NewAble,
    nnum: NewNum,
    nctr: NewCtr,
    nu:   NewU,
    dec:  DecAble,
    decu: DecU
  };

  assign hd  = mem[rp];
  assign plo = hd.pc[IDXW+1:2];
  assign phi = hd.pc[2*IDXW+1:IDXW+2];
  assign ptg = hd.pc[IDXW+TAGW+1:IDXW+2];
  assign unused_ok = ^hd.pc;

  // Acceptance looks only at the registered count.
  assign enq = UpdAble && (cnt != FULLC);
  assign acc = TblWe && TblRdy;

  assign UpdFull = full_q;
  assign UpdBusy = (cnt != '0);
  assign DropCnt = drop;

  // Allocation wins over a decrement to the same table.
  always_comb begin
    eff = '0;
    for (int t = 1; t <= 6; t++)
      eff[t-1] = hd.dec[t-1] &
        ~(hd.nw & (hd.nnum == 3'(t)));
    rem = eff & ~clr;
    low = rem & (~rem + 6'd1);
    lt  = '0;
    lu  = '0;
    unique case (1'b1)
      low[0]: begin
        lt = 3'd1;
        lu = hd.decu[2:0];
      end
      low[1]: begin
        lt = 3'd2;
        lu = hd.decu[5:3];
      end
      low[2]: begin
        lt = 3'd3;
        lu = hd.decu[8:6];
      end
      low[3]: begin
        lt = 3'd4;
        lu = hd.decu[11:9];
      end
      low[4]: begin
        lt = 3'd5;
        lu = hd.decu[14:12];
      end
      low[5]: begin
        lt = 3'd6;
        lu = hd.decu[17:15];
      end
      default: ;
    endcase
  end

  always_comb begin
    st_nx  = st;
    clr_nx = clr;
    pop    = 1'b0;
    unique case (st)
      IDLE: begin
        if (cnt != '0 || enq)
          st_nx = PRV;
      end
      PRV: begin
        if (acc) begin
          if (hd.nw)
            st_nx = NEW;
          else if (|rem)
            st_nx = DEC;
          else
            pop = 1'b1;
        end
      end
      NEW: begin
        if (acc) begin
          if (|rem)
            st_nx = DEC;
          else
            pop = 1'b1;
        end
      end
      DEC: begin
        if (acc) begin
          clr_nx = clr | low;
          if ((rem & ~low) == '0)
            pop = 1'b1;
        end
      end
      default: st_nx = IDLE;
    endcase
    cnt_nx = cnt
           + {{PW{1'b0}}, enq}
           - {{PW{1'b0}}, pop};
    if (pop) begin
      clr_nx = '0;
      st_nx  = (cnt_nx != '0) ? PRV : IDLE;
    end
  end

  always_comb begin
    TblWe    = 1'b0;
    TblSel   = '0;
    TblIdx   = '0;
    TblTag   = '0;
    TblCtr   = '0;
    TblU     = '0;
    TblWrCtr = 1'b0;
    TblWrTag = 1'b0;
    TblWrU   = 1'b0;
    unique case (st)
      PRV: begin
        TblWe    = 1'b1;
        TblSel   = hd.num;
        TblIdx   = hidx(plo, phi, hd.num);
        TblCtr   = hd.ctr;
        TblU     = hd.u;
        TblWrCtr = 1'b1;
        TblWrU   = (hd.num != 3'd0);
      end
      NEW: begin
        TblWe    = 1'b1;
        TblSel   = hd.nnum;
        TblIdx   = hidx(plo, phi, hd.nnum);
        TblTag   = htag(ptg, hd.nnum);
        TblCtr   = hd.nctr;
        TblU     = hd.nu;
        TblWrCtr = 1'b1;
        TblWrTag = 1'b1;
        TblWrU   = 1'b1;
      end
      DEC: begin
        TblWe  = 1'b1;
        TblSel = lt;
        TblIdx = hidx(plo, phi, lt);
        TblU   = lu;
        TblWrU = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      st     <= IDLE;
      cnt    <= '0;
      wp     <= '0;
      rp     <= '0;
      clr    <= '0;
      full_q <= 1'b0;
      drop   <= '0;
    end else begin
      st     <= st_nx;
      cnt    <= cnt_nx;
      clr    <= clr_nx;
      full_q <= (cnt_nx == FULLC);
      if (enq)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      if (UpdAble && !enq && drop != 8'hFF)
        drop <= drop + 8'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (enq)
      mem[wp] <= inb;
  end

endmodule

// File: tb/tb_tage_upd_seq.sv
// Random and directed bench for tage_upd_seq with a
// write-list reference model and a queue scoreboard.
module tb_tage_upd_seq;
  localparam int DEPTH = 4;
  localparam int IDXW  = 8;
  localparam int TAGW  = 8;

  logic            Clk = 1'b0;
  logic            Rest = 1'b1;
  logic            UpdAble = 1'b0;
  logic [31:0]     UpdPc = '0;
  logic [2:0]      UpdNum = '0;
  logic [2:0]      UpdCtr = '0;
  logic [2:0]      UpdU = '0;
  logic            NewAble = 1'b0;
  logic [2:0]      NewNum = '0;
  logic [2:0]      NewCtr = '0;
  logic [2:0]      NewU = '0;
  logic [5:0]      DecAble = '0;
  logic [17:0]     DecU = '0;
  logic            TblRdy = 1'b0;
  logic            UpdFull;
  logic            UpdBusy;
  logic [7:0]      DropCnt;
  logic            TblWe;
  logic [2:0]      TblSel;
  logic [IDXW-1:0] TblIdx;
  logic [TAGW-1:0] TblTag;
  logic [2:0]      TblCtr;
  logic [2:0]      TblU;
  logic            TblWrCtr;
  logic            TblWrTag;
  logic            TblWrU;

  tage_upd_seq #(
    .DEPTH(DEPTH),
    .IDXW (IDXW),
    .TAGW (TAGW)
  ) dut (
    .Clk     (Clk),
    .Rest    (Rest),
    .UpdAble (UpdAble),
    .UpdPc   (UpdPc),
    .UpdNum  (UpdNum),
    .UpdCtr  (UpdCtr),
    .UpdU    (UpdU),
    .NewAble (NewAble),
    .NewNum  (NewNum),
    .NewCtr  (NewCtr),
    .NewU    (NewU),
    .DecAble (DecAble),
    .DecU    (DecU),
    .UpdFull (UpdFull),
    .UpdBusy (UpdBusy),
    .DropCnt (DropCnt),
    .TblWe   (TblWe),
    .TblRdy  (TblRdy),
    .TblSel  (TblSel),
    .TblIdx  (TblIdx),
    .TblTag  (TblTag),
    .TblCtr  (TblCtr),
    .TblU    (TblU),
    .TblWrCtr(TblWrCtr),
    .TblWrTag(TblWrTag),
    .TblWrU  (TblWrU)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  num;
    logic [2:0]  ctr;
    logic [2:0]  u;
    logic        nw;
    logic [2:0]  nnum;
    logic [2:0]  nctr;
    logic [2:0]  nu;
    logic [5:0]  dec;
    logic [17:0] decu;
  } bun_t;

  typedef struct packed {
    logic [2:0]      sel;
    logic [IDXW-1:0] idx;
    logic [TAGW-1:0] tag;
    logic [2:0]      ctr;
    logic [2:0]      u;
    logic            wc;
    logic            wt;
    logic            wu;
    logic            last;
  } wr_t;

  wr_t exq[$];
  wr_t act;
  int  mcount = 0;
  int  mdrop = 0;
  int  pops = 0;
  int  pseen = 0;
  bit  acc_f = 0;
  bit  drop_f = 0;
  int  stall = 0;
  int  total = 0;
  int  passed = 0;

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, a, e);
  endtask

  function automatic logic [IDXW-1:0] m_idx(
    input logic [31:0] pc, input int t);
    int unsigned m, lo, hi;
    m  = (1 << IDXW) - 1;
    lo = (pc >> 2) & m;
    hi = (pc >> (IDXW + 2)) & m;
    return IDXW'(lo ^ (hi >> t));
  endfunction

  function automatic logic [TAGW-1:0] m_tag(
    input logic [31:0] pc, input int t);
    int unsigned m;
    m = (1 << TAGW) - 1;
    return TAGW'(((pc >> (IDXW + 2)) & m) ^ t);
  endfunction

  task automatic expect_bundle(input bun_t b);
    wr_t ws[$];
    wr_t w;
    w = '0;
    w.sel = b.num;
    w.idx = m_idx(b.pc, int'(b.num));
    w.ctr = b.ctr;
    w.u   = b.u;
    w.wc  = 1'b1;
    w.wu  = (b.num != 0);
    ws.push_back(w);
    if (b.nw) begin
      w = '0;
      w.sel = b.nnum;
      w.idx = m_idx(b.pc, int'(b.nnum));
      w.tag = m_tag(b.pc, int'(b.nnum));
      w.ctr = b.nctr;
      w.u   = b.nu;
      w.wc  = 1'b1;
      w.wt  = 1'b1;
      w.wu  = 1'b1;
      ws.push_back(w);
    end
    for (int t = 1; t <= 6; t++) begin
      if (b.dec[t-1] && !(b.nw && int'(b.nnum) == t)) begin
        w = '0;
        w.sel = 3'(t);
        w.idx = m_idx(b.pc, t);
        w.u   = b.decu[3*(t-1) +: 3];
        w.wu  = 1'b1;
        ws.push_back(w);
      end
    end
    ws[ws.size()-1].last = 1'b1;
    foreach (ws[i]) exq.push_back(ws[i]);
  endtask

  task automatic issue(input bun_t b);
    UpdAble = 1'b1;
    UpdPc   = b.pc;
    UpdNum  = b.num;
    UpdCtr  = b.ctr;
    UpdU    = b.u;
    NewAble = b.nw;
    NewNum  = b.nnum;
    NewCtr  = b.nctr;
    NewU    = b.nu;
    DecAble = b.dec;
    DecU    = b.decu;
    if (!Rest) begin
      if (mcount == DEPTH) drop_f = 1;
      else begin
        acc_f = 1;
        expect_bundle(b);
      end
    end
  endtask

  function automatic bun_t rnd();
    bun_t b;
    b.pc   = $urandom;
    b.num  = 3'($urandom_range(7));
    b.ctr  = 3'($urandom_range(7));
    b.u    = 3'($urandom_range(7));
    b.nw   = 1'($urandom_range(1));
    b.nnum = 3'($urandom_range(7));
    b.nctr = 3'($urandom_range(7));
    b.nu   = 3'($urandom_range(7));
    b.dec  = 6'($urandom);
    b.decu = 18'($urandom);
    return b;
  endfunction

  task automatic tick();
    @(posedge Clk);
    if (Rest) begin
      mcount = 0;
      mdrop  = 0;
    end else begin
      mcount = mcount + int'(acc_f) - (pops - pseen);
      if (drop_f && mdrop < 255) mdrop++;
    end
    pseen  = pops;
    acc_f  = 0;
    drop_f = 0;
    #1;
  endtask

  task automatic drain();
    UpdAble = 1'b0;
    TblRdy  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!UpdBusy && exq.size() == 0) break;
      tick();
    end
    chk("drain", {63'd0, UpdBusy}, 64'd0);
  endtask

  always @(negedge Clk) begin
    if (Rest) begin
      exq.delete();
      stall = 0;
    end else begin
      chk("status", {54'd0, UpdFull, UpdBusy, DropCnt},
          {54'd0, mcount == DEPTH, mcount != 0, 8'(mdrop)});
      if (exq.size() == 0) begin
        stall = 0;
        chk("idle_we", {63'd0, TblWe}, 64'd0);
      end else if (TblWe) begin
        stall = 0;
        act = '{sel: TblSel, idx: TblIdx, tag: TblTag,
                ctr: TblCtr, u: TblU, wc: TblWrCtr,
                wt: TblWrTag, wu: TblWrU,
                last: exq[0].last};
        chk("write", 64'(act), 64'(exq[0]));
        if (TblRdy) begin
          if (exq[0].last) pops++;
          void'(exq.pop_front());
        end
      end else begin
        stall++;
        if (stall > 1) begin
          chk("write_latency", {63'd0, TblWe}, 64'd1);
          stall = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  bun_t b1, b2;

  initial begin
    b1 = '0;
    b1.pc = 32'h0000_1234; b1.num = 3'd1;
    b1.ctr = 3'd5; b1.u = 3'd2;
    b2 = '0;
    b2.pc = 32'h0000_1234; b2.num = 3'd2;
    b2.ctr = 3'd3; b2.u = 3'd1;
    b2.nw = 1'b1; b2.nnum = 3'd4;
    b2.nctr = 3'd4; b2.nu = 3'd0;
    b2.dec = 6'b101000;
    b2.decu = {3'd1, 3'd0, 3'd7, 9'd0};

    Rest = 1'b1;
    for (int i = 0; i < 2; i++) begin
      UpdAble = 1'($urandom_range(1));
      UpdPc   = $urandom;
      NewAble = 1'($urandom_range(1));
      DecAble = 6'($urandom);
      TblRdy  = 1'($urandom_range(1));
      tick();
      chk("reset_out",
          {25'd0, UpdFull, UpdBusy, DropCnt, TblWe, TblSel,
           TblIdx, TblTag, TblCtr, TblU, TblWrCtr,
           TblWrTag, TblWrU}, 64'd0);
    end
    Rest = 1'b0;
    UpdAble = 1'b0;
    TblRdy = 1'b1;
    repeat (3) tick();

    issue(b1);
    tick();
    UpdAble = 1'b0;
    chk("prv_vec",
        {44'd0, TblWe, TblSel, TblIdx, TblCtr, TblU,
         TblWrCtr, TblWrU, TblWrTag},
        {44'd0, 1'b1, 3'd1, 8'h8F, 3'd5, 3'd2,
         1'b1, 1'b1, 1'b0});
    tick();
    chk("prv_done", {62'd0, TblWe, UpdBusy}, 64'd0);

    issue(b2);
    tick();
    UpdAble = 1'b0;
    chk("full_prv", {61'd0, TblSel}, 64'd2);
    tick();
    chk("full_new", {52'd0, TblSel, TblTag, TblWrTag},
        {52'd0, 3'd4, 8'h00, 1'b1});
    tick();
    chk("full_dec",
        {55'd0, TblSel, TblU, TblWrCtr, TblWrTag, TblWrU},
        {55'd0, 3'd6, 3'd1, 3'b001});
    tick();
    chk("full_end", {63'd0, TblWe}, 64'd0);

    issue(b2);
    tick();
    UpdAble = 1'b0;
    tick();
    TblRdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold",
          {43'd0, TblWe, TblSel, TblIdx, TblTag, TblWrTag},
          {43'd0, 1'b1, 3'd4, 8'h8D, 8'h00, 1'b1});
    end
    TblRdy = 1'b1;
    tick();
    chk("stall_dec", {60'd0, TblWe, TblSel}, {60'd0, 1'b1, 3'd6});
    tick();

    TblRdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue(rnd());
      tick();
      if (i == 3) chk("full_flag", {63'd0, UpdFull}, 64'd1);
    end
    UpdAble = 1'b0;
    chk("drop2", {56'd0, DropCnt}, 64'd2);
    drain();

    for (int i = 0; i < 400; i++) begin
      Rest = ($urandom_range(199) == 0);
      if ($urandom_range(99) < 40) issue(rnd());
      else UpdAble = 1'b0;
      TblRdy = ($urandom_range(99) < 70);
      tick();
    end
    Rest = 1'b0;
    drain();

    TblRdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(rnd());
      tick();
    end
    UpdAble = 1'b0;
    TblRdy = 1'b1;
    tick();
    Rest = 1'b1;
    tick();
    chk("rst_we", {63'd0, TblWe}, 64'd0);
    Rest = 1'b0;
    repeat (8) tick();
    chk("rst_flush", {62'd0, TblWe, UpdBusy}, 64'd0);

    TblRdy = 1'b0;
    for (int i = 0; i < 262; i++) begin
      issue(rnd());
      tick();
    end
    UpdAble = 1'b0;
    chk("drop_sat", {56'd0, DropCnt}, 64'hFF);
    drain();

    chk("end_empty", 64'(exq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tage_upd_seq.md
# tage_upd_seq

TAGE update sequencer, directly downstream of the FTQ. It buffers the per-branch update bundles the FTQ emits on each resolved branch. Each bundle holds a provider counter/useful write, an optional new-entry allocation, and up to six useful-counter decrements. The block serialises these into single-port writes to the TAGE base and tagged tables, one write per accepted cycle, with backpressure to ctrl so no update is lost.

## Interface
Parameters:
- DEPTH, 4 — bundle queue entries, power of two ≥2
- IDXW, 8 — table index width; 2*IDXW+1 ≤ 31
- TAGW, 8 — tag width; IDXW+TAGW+1 ≤ 31

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Rest  in  1  reset, synchronous, active-high
- UpdAble  in  1  bundle valid, one cycle per bundle
- UpdPc  in  32  branch PC
- UpdNum  in  3  provider table, 0=base, 1..6 tagged
- UpdCtr  in  3  provider prediction counter to write
- UpdU  in  3  provider useful counter to write
- NewAble  in  1  allocation requested
- NewNum  in  3  allocation table, 1..6
- NewCtr  in  3  allocation counter value
- NewU  in  3  allocation useful value
- DecAble  in  6  bit t-1 set = decrement useful of table t
- DecU  in  18  decremented useful values, {t6,…,t1}, 3 bits each
- UpdFull  out  1  queue full; ctrl stalls branch retire
- UpdBusy  out  1  queue non-empty or write in progress
- DropCnt  out  8  saturating count of bundles dropped while full
- TblWe  out  1  table write request
- TblRdy  in  1  table accepts write this cycle
- TblSel  out  3  target table 0..6
- TblIdx  out  IDXW  write index
- TblTag  out  TAGW  write tag
- TblCtr  out  3  counter data
- TblU  out  3  useful data
- TblWrCtr / TblWrTag / TblWrU  out  1 each  field write enables

## Operation
- Queue: circular FIFO of DEPTH bundles; wr/rd pointers wrap modulo DEPTH; count 0..DEPTH.
- Enqueue: UpdAble & count<DEPTH. UpdAble & count==DEPTH → bundle discarded, DropCnt+1 (saturates at 255).
- Pop when the head's last write is accepted. Enqueue and pop in the same cycle leave count unchanged.
- Enqueue acceptance uses the registered count only. A same-cycle pop does not free a slot for that cycle's enqueue.
- Per-head op list is latched when the bundle becomes head, in this order:
  - PRV: always executed.
  - NEW: executed if NewAble.
  - DEC: one op per set DecAble bit, ascending table number. A DEC bit equal to NewNum is cleared when NewAble (allocation wins).
- FSM states: IDLE, PRV, NEW, DEC.
  - IDLE→PRV when count≠0.
  - PRV→NEW, else DEC, else (pop) PRV/IDLE on accept.
  - NEW→DEC, else pop on accept.
  - DEC: clear the lowest set mask bit on accept; pop when the mask becomes empty.
  - After a pop: next head → PRV, otherwise IDLE.
- Hash for table t (t=0..6):
  - idx_t = PC[IDXW+1:2] ^ (PC[2*IDXW+1:IDXW+2] >> t)
  - tag_t = PC[IDXW+TAGW+1:IDXW+2] ^ t (t zero-extended)
- Write fields:
  - PRV: Sel=UpdNum, Ctr=UpdCtr, U=UpdU; WrCtr=1, WrU=(UpdNum≠0), WrTag=0.
  - NEW: Sel=NewNum, Ctr=NewCtr, U=NewU, Tag=tag; WrCtr=WrU=WrTag=1.
  - DEC: Sel=t, U=DecU_t; WrU=1 only.
  - Unused data fields are 0.
- UpdNum=0 with NewAble is legal. Out-of-range table numbers (7) are forwarded unchanged; no checking is done.

## Timing
- All outputs are driven from registers or head-entry storage; there are no input-to-output combinational paths.
- Reset: all outputs 0, count 0, pointers 0, FSM IDLE, DropCnt 0. Reset mid-sequence abandons the current head and flushes all queued bundles; TblWe is 0 in the cycle after the reset edge.
- Latency: bundle enqueued at edge N gives its first TblWe=1 in cycle N+1 if the queue was empty.
- Throughput: one accepted write per cycle; back-to-back bundles have no bubble.
- A write completes on an edge with TblWe & TblRdy. While TblRdy=0, every Tbl* output holds stable.
- UpdFull = (count==DEPTH), registered. It updates the cycle after the enqueue/pop edge.
- UpdBusy = (count≠0).

## Test plan
- Reset: assert Rest 2 cycles with random inputs → every output 0, DropCnt 0; release → TblWe stays 0 with no UpdAble.
- Provider-only: PC=0x00001234, UpdNum=1, UpdCtr=5, UpdU=2, TblRdy=1 → next cycle TblWe=1, Sel=1, Idx=0x8F, Ctr=5, U=2, WrCtr=1, WrU=1, WrTag=0; following cycle TblWe=0, UpdBusy=0.
- Full bundle: PC=0x00001234, UpdNum=2, NewAble NewNum=4 Ctr=4 U=0, DecAble=6'b101000, DecU t6=1 → three consecutive writes:
  - Sel=2
  - Sel=4, Tag=0x00, WrTag=1
  - Sel=6, U=1, WrU only
  - t4 DEC suppressed.
- Stall: same bundle, TblRdy=0 for 3 cycles during NEW → Sel/Idx/Tag/data held for 3 cycles; DEC issued only after TblRdy=1.
- Overflow: DEPTH=4, TblRdy=0, six bundles enqueued back-to-back → UpdFull=1 after the 4th, DropCnt=2; release TblRdy → first 4 bundles drained in order, then UpdBusy=0.
- Reset mid-drain: 3 bundles queued, Rest during the 2nd write → TblWe=0 next cycle; no further writes after release.
